// File: rtl/bus_pkg.sv
// Purpose : shared bus encodings, arbiter state type and index helpers for the minx bus.
// Latency : n/a (package, no logic).
// Backpressure: n/a.
// Contents: BUS_* status encodings (shared with s1c88/prc), arb_state_t, OWNER_CPU, wrap_inc().
package bus_pkg;

  // Master indices are carried in 2 bits, enough for up to 4 secondary masters.
  localparam int IDX_W = 2;

  // bus_status encodings; IDLE is what the bus shows during arbitration turnaround.
  localparam logic [1:0] BUS_IDLE      = 2'b00;
  localparam logic [1:0] BUS_MEM       = 2'b01;
  localparam logic [1:0] BUS_IRQ       = 2'b10;
  localparam logic [1:0] BUS_MEM_FETCH = 2'b11;

  localparam logic [2:0] OWNER_CPU = 3'd0;

  typedef enum logic [1:0] {
    CPU_OWNS = 2'd0,
    WAIT_ACK = 2'd1,
    GRANTED  = 2'd2,
    RELEASE  = 2'd3
  } arb_state_t;

  // Next index after idx, wrapping at n.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    int t;
    t = int'(idx) + 1;
    if (t >= n) t = 0;
    return IDX_W'(t);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose : combinational round-robin picker; lowest index at or after ptr with req set, wrapping.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; valid is low when no request is pending.
// Ports   : req (request vector), ptr (search start) -> idx (winner), valid (any request).
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int best;

  // Pick the requester with the smallest forward distance from ptr.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    best  = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (((i + NUM_REQ - int'(ptr)) % NUM_REQ) < best)) begin
        best  = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Purpose : shares the system bus between the s1c88 CPU (default owner) and NUM_REQ masters.
// Latency : req to cpu_bus_request 1 cycle; cpu_bus_ack to gnt 1 cycle; one idle turnaround per release.
// Backpressure: masters hold req until gnt is seen; CPU releases via the bus_request/bus_ack handshake.
// Ports   : clk/reset; req/gnt/owner; m_* master buses; cpu_* CPU bus and handshake; shared bus outputs.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [2:0]            owner,
  input  logic [NUM_REQ*ADDR_W-1:0] m_address,
  input  logic [NUM_REQ*DATA_W-1:0] m_data_out,
  input  logic [NUM_REQ-1:0]    m_write,
  input  logic [NUM_REQ-1:0]    m_read,
  input  logic [NUM_REQ*2-1:0]  m_bus_status,
  input  logic [ADDR_W-1:0]     cpu_address_out,
  input  logic [DATA_W-1:0]     cpu_data_out,
  input  logic                  cpu_write,
  input  logic                  cpu_read,
  input  logic [1:0]            cpu_bus_status,
  output logic                  cpu_bus_request,
  input  logic                  cpu_bus_ack,
  output logic [ADDR_W-1:0]     address_out,
  output logic [DATA_W-1:0]     data_out,
  output logic                  write,
  output logic                  read,
  output logic [1:0]            bus_status
);

  arb_state_t         state, state_n;
  logic [IDX_W-1:0]   winner, winner_n;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [2:0]         owner_n;
  logic               cpu_bus_request_n;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               win_req;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] x);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (x == IDX_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [2:0] owner_of(input logic [IDX_W-1:0] x);
    return 3'(x) + 3'd1;
  endfunction

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign win_req = |(req & onehot(winner));

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= CPU_OWNS;
      winner          <= '0;
      rr_ptr          <= '0;
      gnt             <= '0;
      owner           <= OWNER_CPU;
      cpu_bus_request <= 1'b0;
    end else begin
      state           <= state_n;
      winner          <= winner_n;
      rr_ptr          <= rr_ptr_n;
      gnt             <= gnt_n;
      owner           <= owner_n;
      cpu_bus_request <= cpu_bus_request_n;
    end
  end

  always_comb begin
    state_n           = state;
    winner_n          = winner;
    rr_ptr_n          = rr_ptr;
    gnt_n             = gnt;
    owner_n           = owner;
    cpu_bus_request_n = cpu_bus_request;
    case (state)
      CPU_OWNS: begin
        if (pick_vld) begin
          winner_n          = pick_idx;
          state_n           = WAIT_ACK;
          cpu_bus_request_n = 1'b1;
        end
      end
      WAIT_ACK: begin
        // A withdrawn request takes priority over an ack arriving on the same edge.
        if (!win_req) begin
          if (pick_vld) begin
            winner_n = pick_idx;
          end else begin
            state_n           = CPU_OWNS;
            cpu_bus_request_n = 1'b0;
          end
        end else if (cpu_bus_ack) begin
          state_n = GRANTED;
          gnt_n   = onehot(winner);
          owner_n = owner_of(winner);
        end
      end
      GRANTED: begin
        // Losing ack mid-grant is a CPU protocol violation; end the grant cleanly.
        if (!win_req || !cpu_bus_ack) begin
          state_n  = RELEASE;
          gnt_n    = '0;
          owner_n  = OWNER_CPU;
          rr_ptr_n = wrap_inc(winner, NUM_REQ);
        end
      end
      RELEASE: begin
        // CPU still holds off the bus, so a waiting master is granted without a new handshake.
        if (pick_vld) begin
          winner_n = pick_idx;
          state_n  = GRANTED;
          gnt_n    = onehot(pick_idx);
          owner_n  = owner_of(pick_idx);
        end else begin
          state_n           = CPU_OWNS;
          cpu_bus_request_n = 1'b0;
        end
      end
      default: state_n = CPU_OWNS;
    endcase
  end

  // Bus mux depends only on registered state/winner, never on req or ack directly.
  always_comb begin
    address_out = cpu_address_out;
    data_out    = cpu_data_out;
    write       = cpu_write;
    read        = cpu_read;
    bus_status  = cpu_bus_status;
    if (state == GRANTED) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (winner == IDX_W'(i)) begin
          address_out = m_address[i*ADDR_W +: ADDR_W];
          data_out    = m_data_out[i*DATA_W +: DATA_W];
          write       = m_write[i];
          read        = m_read[i];
          bus_status  = m_bus_status[i*2 +: 2];
        end
      end
    end else if (state == RELEASE) begin
      address_out = '0;
      data_out    = '0;
      write       = 1'b0;
      read        = 1'b0;
      bus_status  = BUS_IDLE;
    end
  end

endmodule
